// File: rtl/pc_unit.sv
// Program counter with increment/decrement, relative branch, absolute jump and a
// small LIFO return-address stack for call/return. Errors are sticky until reset.
module pc_unit #(
    parameter int             N         = 32,
    parameter int             STEP      = 4,
    parameter int             DEPTH     = 4,
    parameter logic [N-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [2:0]   op,
    input  logic [N-1:0] imm,
    output logic [N-1:0] pc,
    output logic [N-1:0] ret_addr,
    output logic         stack_full,
    output logic         stack_empty,
    output logic         err
);

    localparam int           CW     = $clog2(DEPTH + 1);
    localparam logic [N-1:0] STEP_N = N'(STEP);

    typedef enum logic [2:0] {
        OP_HOLD   = 3'b000,
        OP_INC    = 3'b001,
        OP_DEC    = 3'b010,
        OP_BRANCH = 3'b011,
        OP_JUMP   = 3'b100,
        OP_CALL   = 3'b101,
        OP_RET    = 3'b110,
        OP_RSVD   = 3'b111
    } op_e;

    logic [N-1:0]  stack [DEPTH];
    logic [CW-1:0] count;
    logic [N-1:0]  top_val;
    logic [N-1:0]  next_pc;
    logic          push;
    logic          pop;
    logic          set_err;

    assign stack_full  = (count == CW'(DEPTH));
    assign stack_empty = (count == '0);
    // Entries are never reset; gating by count keeps stale contents hidden.
    assign ret_addr    = stack_empty ? '0 : top_val;

    always_comb begin
        top_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count == CW'(i + 1)) top_val = stack[i];
        end
    end

    always_comb begin
        next_pc = pc;
        push    = 1'b0;
        pop     = 1'b0;
        set_err = 1'b0;
        case (op_e'(op))
            OP_HOLD:   next_pc = pc;
            OP_INC:    next_pc = pc + STEP_N;
            OP_DEC:    next_pc = pc - STEP_N;
            OP_BRANCH: next_pc = pc + imm;
            OP_JUMP:   next_pc = imm;
            OP_CALL: begin
                if (stack_full) begin
                    set_err = 1'b1;
                end else begin
                    push    = 1'b1;
                    next_pc = imm;
                end
            end
            OP_RET: begin
                if (stack_empty) begin
                    set_err = 1'b1;
                end else begin
                    pop     = 1'b1;
                    next_pc = top_val;
                end
            end
            default:   set_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_VAL;
            count <= '0;
            err   <= 1'b0;
        end else if (en) begin
            pc <= next_pc;
            if (push) count <= count + 1'b1;
            if (pop)  count <= count - 1'b1;
            if (set_err) err <= 1'b1;
        end
    end

    // Slot `count` receives the pushed return address; a write that races a reset
    // lands above the cleared count and stays invisible.
    always_ff @(posedge clk) begin
        if (en && push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (count == CW'(i)) stack[i] <= pc + STEP_N;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit (N=8, STEP=4, DEPTH=2): directed sequences plus randomized
// operations compared against a queue-based reference model.
module tb_pc_unit;

    localparam int N     = 8;
    localparam int DEPTH = 2;

    localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, DEC = 3'd2, BRANCH = 3'd3,
                           JUMP = 3'd4, CALL = 3'd5, RET = 3'd6, RSVD = 3'd7;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [N-1:0] imm = '0;
    logic [N-1:0] pc;
    logic [N-1:0] ret_addr;
    logic         stack_full;
    logic         stack_empty;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: program counter, return-address stack as a queue, sticky error.
    logic [N-1:0] m_pc;
    logic [N-1:0] exp_q[$];
    logic         m_err;

    pc_unit #(.N(N), .STEP(4), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .imm(imm),
        .pc(pc), .ret_addr(ret_addr), .stack_full(stack_full),
        .stack_empty(stack_empty), .err(err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc  = 8'h00;
        exp_q.delete();
        m_err = 1'b0;
    endtask

    task automatic model_apply(input logic e, input logic [2:0] o, input logic [N-1:0] im);
        if (!e) return;
        case (o)
            INC:    m_pc = m_pc + 8'd4;
            DEC:    m_pc = m_pc - 8'd4;
            BRANCH: m_pc = m_pc + im;
            JUMP:   m_pc = im;
            CALL: begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(m_pc + 8'd4);
                    m_pc = im;
                end else m_err = 1'b1;
            end
            RET: begin
                if (exp_q.size() > 0) m_pc = exp_q.pop_back();
                else m_err = 1'b1;
            end
            RSVD:   m_err = 1'b1;
            default: ;
        endcase
    endtask

    function automatic logic [2*N+2:0] model_vec();
        logic [N-1:0] top;
        top = (exp_q.size() > 0) ? exp_q[$] : 8'h00;
        return {m_pc, top, exp_q.size() == DEPTH, exp_q.size() == 0, m_err};
    endfunction

    // Drive one operation across a rising edge, then sample 1 time unit later.
    task automatic do_op(input logic e, input logic [2:0] o, input logic [N-1:0] im);
        @(negedge clk);
        en  = e;
        op  = o;
        imm = im;
        @(posedge clk);
        #1;
        model_apply(e, o, im);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        op  = INC;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({pc, ret_addr, stack_full, stack_empty, err} !== {8'h00, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_state: got pc=%h ra=%h full=%b empty=%b err=%b, expected pc=00 ra=00 full=0 empty=1 err=0",
                     pc, ret_addr, stack_full, stack_empty, err);
        end
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_inc();
        logic [N-1:0] exp_pc [3] = '{8'h04, 8'h08, 8'h0C};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, INC, 8'h00);
            n_checks++;
            if (pc !== exp_pc[i] || err !== 1'b0) begin
                n_errors++;
                $display("FAIL inc_%0d: got pc=%h err=%b, expected pc=%h err=0", i, pc, err, exp_pc[i]);
            end
        end
    endtask

    task automatic test_dec_jump();
        logic [2:0]   ops    [3] = '{DEC, JUMP, INC};
        logic [N-1:0] imms   [3] = '{8'h00, 8'hFE, 8'h00};
        logic [N-1:0] exp_pc [3] = '{8'hFC, 8'hFE, 8'h02};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, ops[i], imms[i]);
            n_checks++;
            if (pc !== exp_pc[i] || err !== 1'b0) begin
                n_errors++;
                $display("FAIL dec_jump_%0d: got pc=%h err=%b, expected pc=%h err=0", i, pc, err, exp_pc[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [N-1:0] imms   [2] = '{8'hF8, 8'h08};
        logic [N-1:0] exp_pc [2] = '{8'h08, 8'h10};
        apply_reset();
        do_op(1'b1, JUMP, 8'h10);
        for (int i = 0; i < 2; i++) begin
            do_op(1'b1, BRANCH, imms[i]);
            n_checks++;
            if (pc !== exp_pc[i]) begin
                n_errors++;
                $display("FAIL branch_%0d: got pc=%h, expected pc=%h", i, pc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_call_ret();
        logic [2:0]   ops   [6] = '{CALL, CALL, CALL, RET, RET, RET};
        logic [N-1:0] imms  [6] = '{8'h40, 8'h80, 8'h90, 8'h00, 8'h00, 8'h00};
        logic [N-1:0] e_pc  [6] = '{8'h40, 8'h80, 8'h80, 8'h44, 8'h14, 8'h14};
        logic [N-1:0] e_ra  [6] = '{8'h14, 8'h44, 8'h44, 8'h14, 8'h00, 8'h00};
        logic         e_ful [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic         e_emp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         e_err [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        apply_reset();
        do_op(1'b1, JUMP, 8'h10);
        for (int i = 0; i < 6; i++) begin
            do_op(1'b1, ops[i], imms[i]);
            n_checks++;
            if ({pc, ret_addr, stack_full, stack_empty, err} !==
                {e_pc[i], e_ra[i], e_ful[i], e_emp[i], e_err[i]}) begin
                n_errors++;
                $display("FAIL call_ret_%0d: got pc=%h ra=%h full=%b empty=%b err=%b, expected pc=%h ra=%h full=%b empty=%b err=%b",
                         i, pc, ret_addr, stack_full, stack_empty, err,
                         e_pc[i], e_ra[i], e_ful[i], e_emp[i], e_err[i]);
            end
        end
    endtask

    task automatic test_enable();
        apply_reset();
        do_op(1'b1, JUMP, 8'h20);
        do_op(1'b1, CALL, 8'h60);
        for (int i = 0; i < 8; i++) begin
            do_op(1'b0, 3'(i), 8'h33);
            n_checks++;
            if ({pc, ret_addr, err} !== {8'h60, 8'h24, 1'b0}) begin
                n_errors++;
                $display("FAIL en_low_op%0d: got pc=%h ra=%h err=%b, expected pc=60 ra=24 err=0", i, pc, ret_addr, err);
            end
        end
        do_op(1'b1, RSVD, 8'h00);
        n_checks++;
        if (pc !== 8'h60 || err !== 1'b1 || ret_addr !== 8'h24) begin
            n_errors++;
            $display("FAIL reserved_op: got pc=%h ra=%h err=%b, expected pc=60 ra=24 err=1", pc, ret_addr, err);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_op(1'b1, RSVD, 8'h00);
        do_op(1'b1, JUMP, 8'h7C);
        do_op(1'b1, CALL, 8'h80);
        n_checks++;
        if (pc !== 8'h80 || ret_addr !== 8'h80 || err !== 1'b1 || stack_empty !== 1'b0) begin
            n_errors++;
            $display("FAIL async_setup: got pc=%h ra=%h err=%b empty=%b, expected pc=80 ra=80 err=1 empty=0",
                     pc, ret_addr, err, stack_empty);
        end
        @(negedge clk);
        en = 1'b1;
        op = INC;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({pc, ret_addr, stack_full, stack_empty, err} !== {8'h00, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL async_reset: got pc=%h ra=%h full=%b empty=%b err=%b, expected pc=00 ra=00 full=0 empty=1 err=0",
                     pc, ret_addr, stack_full, stack_empty, err);
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        model_reset();
        // Stale entry must stay hidden: a RET after reset errors and keeps pc.
        do_op(1'b1, RET, 8'h00);
        n_checks++;
        if (pc !== 8'h00 || err !== 1'b1 || ret_addr !== 8'h00) begin
            n_errors++;
            $display("FAIL ret_after_reset: got pc=%h ra=%h err=%b, expected pc=00 ra=00 err=1", pc, ret_addr, err);
        end
    endtask

    task automatic test_random();
        logic         e;
        logic [2:0]   o;
        logic [N-1:0] im;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 99) apply_reset();
            e  = ($urandom_range(0, 9) != 0);
            // Reserved op is rare so the sticky error does not dominate every run.
            o  = ($urandom_range(0, 19) == 0) ? RSVD : 3'($urandom_range(0, 6));
            im = 8'($urandom);
            do_op(e, o, im);
            n_checks++;
            if ({pc, ret_addr, stack_full, stack_empty, err} !== model_vec()) begin
                n_errors++;
                $display("FAIL random_%0d en=%b op=%0d imm=%h: got %h_%h_%b%b%b, expected %h",
                         i, e, o, im, pc, ret_addr, stack_full, stack_empty, err, model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_inc();
        test_dec_jump();
        test_branch();
        test_call_ret();
        test_enable();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter N, default 32: width of the program counter, immediate and stack entries.
REQ-002 The block SHALL have parameter STEP, default 4: increment/decrement amount, taken modulo 2^N.
REQ-003 The block SHALL have parameter DEPTH, default 4 (minimum 1): number of return-address stack entries.
REQ-004 The block SHALL have parameter RESET_VAL, default 0: PC value after reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port en, input, 1 bit: operation enable; when low, no state changes.
REQ-008 The block SHALL have port op, input, 3 bits: operation select, encoded per REQ-013.
REQ-009 The block SHALL have port imm, input, N bits: branch offset (two's complement) or absolute target.
REQ-010 The block SHALL have port pc, output, N bits: current program counter, driven directly from a register.
REQ-011 The block SHALL have port ret_addr, output, N bits: top-of-stack entry, 0 when the stack is empty.
REQ-012 The block SHALL have ports stack_full and stack_empty (output, 1 bit each) and err (output, 1 bit, sticky error).

Function
REQ-013 op encoding SHALL be: 000 HOLD, 001 INC, 010 DEC, 011 BRANCH, 100 JUMP, 101 CALL, 110 RET, 111 reserved.
REQ-014 All operations SHALL be sampled on a rising clk edge with en=1, and their results SHALL be visible on the outputs after that edge (one-cycle latency).
REQ-015 HOLD SHALL leave all state unchanged.
REQ-016 INC SHALL set pc <= pc+STEP and DEC SHALL set pc <= pc-STEP, both modulo 2^N with silent wrap-around and no error.
REQ-017 BRANCH SHALL set pc <= pc+imm, modulo 2^N, with imm treated as two's complement.
REQ-018 JUMP SHALL set pc <= imm.
REQ-019 CALL when the stack is not full SHALL push (pc+STEP) mod 2^N, increment the count, and set pc <= imm in the same edge.
REQ-020 CALL when the stack is full SHALL leave pc and the stack unchanged and set err.
REQ-021 RET when the stack is not empty SHALL set pc <= top entry, pop it, and decrement the count.
REQ-022 RET when the stack is empty SHALL leave pc unchanged and set err.
REQ-023 The stack SHALL be LIFO with an occupancy count of width clog2(DEPTH+1).
REQ-024 stack_full SHALL equal (count==DEPTH) and stack_empty SHALL equal (count==0); both are derived from registered state only.
REQ-025 op=111 SHALL leave pc and the stack unchanged and set err.
REQ-026 Once set, err SHALL remain 1 until reset.
REQ-027 With en=0, pc, the stack, the count and err SHALL all hold, for every value of op.

Reset
REQ-028 While rst=1, outputs SHALL be pc=RESET_VAL, count=0 (stack_empty=1, stack_full=0), ret_addr=0 and err=0, regardless of clk.
REQ-029 Assertion of rst mid-operation SHALL take effect immediately, without waiting for a clock edge, and any operation in progress SHALL be discarded.
REQ-030 After rst deasserts, the first operation SHALL be the one sampled on the first rising clk edge with en=1.
REQ-031 Stack entry contents SHALL NOT be observable after reset until they are rewritten.

Verification (N=8, STEP=4, DEPTH=2, RESET_VAL=0)
REQ-032 Reset, then INC on three edges -> pc shall read 0x04, 0x08, 0x0C; err=0.
REQ-033 From pc=0x00: DEC -> pc=0xFC. Then JUMP imm=0xFE -> pc=0xFE. Then INC -> pc=0x02; err remains 0.
REQ-034 From pc=0x10: BRANCH imm=0xF8 -> pc=0x08. Then BRANCH imm=0x08 -> pc=0x10.
REQ-035 Call/return sequence from pc=0x10, one step per edge:
- CALL 0x40 -> pc=0x40, ret_addr=0x14.
- CALL 0x80 -> pc=0x80, ret_addr=0x44, stack_full=1.
- CALL 0x90 -> pc=0x80, err=1.
- RET -> pc=0x44.
- RET -> pc=0x14, stack_empty=1, ret_addr=0.
- RET -> pc=0x14, err stays 1.
REQ-036 en=0 with op=001 for 3 edges -> pc unchanged. Then en=1 with op=111 -> pc unchanged, err=1.
REQ-037 With pc=0x80 and one stack entry, assert rst between clock edges -> pc=0x00, stack_empty=1 and err=0 immediately, before the next edge.
